edge_scale_input: RTL and testbench

Avalon-ST video sink adapter that accepts 12-bit RGB444 pixel packets and expands them to 24-bit RGB888 for the edge-detect filter core. It is the input-side counterpart of the core's output scaler, which narrows 24-bit to 12-bit. It registers the stream through a two-entry skid buffer, so `ready_out` is a registered signal. It enforces packet framing, discarding beats that arrive outside a packet, and counts completed frames.

---
 rtl/edge_pkg.sv | 34 +++
 rtl/st_skid_buffer.sv | 59 +++++
 rtl/edge_scale_input.sv | 87 ++++++++
 tb/tb_edge_scale_input.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared types for the edge-detect scalers: RGB444/RGB888 pixel structs,
// channel expansion and the input-side framing FSM state.
package edge_pkg;

   localparam int RGB444_W = 12;
   localparam int RGB888_W = 24;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb888_t;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } scale_in_state_e;

   // Replicating the nibble maps 0x0 to 0x00 and 0xF to 0xFF, so full scale is kept.
   function automatic rgb888_t expand4to8(input rgb444_t px);
      rgb888_t o;
      o.r = {px.r, px.r};
      o.g = {px.g, px.g};
      o.b = {px.b, px.b};
      return o;
   endfunction

endpackage

// File: rtl/st_skid_buffer.sv
// Two-entry Avalon-ST register slice (output register + skid register) carrying
// data, sop and eop; the sink ready is registered as the inverse of skid occupancy.
module st_skid_buffer #(
   parameter int W = 24
) (
   input  logic         clock_clk,
   input  logic         reset_n,
   input  logic [W-1:0] snk_data,
   input  logic         snk_sop,
   input  logic         snk_eop,
   input  logic         snk_valid,
   output logic         snk_ready,
   output logic [W-1:0] src_data,
   output logic         src_sop,
   output logic         src_eop,
   output logic         src_valid,
   input  logic         src_ready
);

   logic [W+1:0] out_beat;
   logic [W+1:0] skid_beat;
   logic         out_valid;
   logic         skid_valid;
   logic [W+1:0] snk_beat;

   assign snk_beat  = {snk_sop, snk_eop, snk_data};
   assign snk_ready = !skid_valid;

   // NOTE: the payload registers are reset as well, because the reset value of
   // the output data is observable on the port, not just the valid flag.
   always_ff @(posedge clock_clk or negedge reset_n) begin
      if (!reset_n) begin
         out_beat   <= '0;
         skid_beat  <= '0;
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (!out_valid || src_ready) begin
         // NOTE: non-blocking assignments here so every register samples the
         // pre-edge values; blocking would let skid->out and out->port race.
         if (skid_valid) begin
            out_beat   <= skid_beat;
            out_valid  <= 1'b1;
            skid_valid <= 1'b0;
         end else begin
            out_valid <= snk_valid;
            if (snk_valid) out_beat <= snk_beat;
         end
      end else if (snk_valid && !skid_valid) begin
         skid_beat  <= snk_beat;
         skid_valid <= 1'b1;
      end
   end

   assign src_sop   = out_beat[W+1];
   assign src_eop   = out_beat[W];
   assign src_data  = out_beat[W-1:0];
   assign src_valid = out_valid;

endmodule

// File: rtl/edge_scale_input.sv
// Avalon-ST RGB444 -> RGB888 sink adapter: drops beats outside packets, counts
// frames, registers the stream. Define EDGE_SCALE_IN_FRAME_CHECK_EN for frame_err.
module edge_scale_input
   import edge_pkg::*;
#(
   parameter int FRAME_W = 640,
   parameter int FRAME_H = 480,
   parameter int CNT_W   = 20
) (
   input  logic                clock_clk,
   input  logic                reset_n,
   input  logic [RGB444_W-1:0] data_in,
   input  logic                sop_in,
   input  logic                eop_in,
   input  logic                valid_in,
   output logic                ready_out,
   output logic [RGB888_W-1:0] data_out,
   output logic                sop_out,
   output logic                eop_out,
   output logic                valid_out,
   input  logic                ready_in,
   output logic [15:0]         frame_count,
   output logic                frame_err
);

   scale_in_state_e  state;
   logic [CNT_W-1:0] pix_cnt;
   logic             accept;
   logic             fwd;
   rgb888_t          px_exp;

   assign accept = valid_in && ready_out;
   // Outside a packet only a sop beat is forwarded; everything else is consumed.
   assign fwd    = accept && (state == ACTIVE || sop_in);
   assign px_exp = expand4to8(rgb444_t'(data_in));

   st_skid_buffer #(.W(RGB888_W)) u_skid (
      .clock_clk (clock_clk),
      .reset_n   (reset_n),
      .snk_data  (px_exp),
      .snk_sop   (sop_in),
      .snk_eop   (eop_in),
      .snk_valid (fwd),
      .snk_ready (ready_out),
      .src_data  (data_out),
      .src_sop   (sop_out),
      .src_eop   (eop_out),
      .src_valid (valid_out),
      .src_ready (ready_in)
   );

   always_ff @(posedge clock_clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         pix_cnt     <= '0;
         frame_count <= '0;
      end else if (fwd) begin
         pix_cnt <= sop_in ? CNT_W'(1) : pix_cnt + CNT_W'(1);
         if (eop_in) begin
            state       <= IDLE;
            frame_count <= frame_count + 16'd1;
         end else begin
            state <= ACTIVE;
         end
      end
   end

`ifdef EDGE_SCALE_IN_FRAME_CHECK_EN
   localparam logic [CNT_W-1:0] FRAME_PIX = CNT_W'(FRAME_W * FRAME_H);

   logic [CNT_W-1:0] cnt_incl;
   logic             err_set;

   // Pixel count including the current beat, as seen on an eop.
   assign cnt_incl = sop_in ? CNT_W'(1) : pix_cnt + CNT_W'(1);
   assign err_set  = fwd && ((state == ACTIVE && sop_in) ||
                             (eop_in && cnt_incl != FRAME_PIX));

   always_ff @(posedge clock_clk or negedge reset_n) begin
      if (!reset_n)     frame_err <= 1'b0;
      else if (err_set) frame_err <= 1'b1;
   end
`else
   assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_edge_scale_input.sv
// Directed bench for edge_scale_input with FRAME_W=4, FRAME_H=2; frame_err
// expectations follow whether EDGE_SCALE_IN_FRAME_CHECK_EN is defined.
module tb_edge_scale_input;

   localparam int FW = 4;
   localparam int FH = 2;
`ifdef EDGE_SCALE_IN_FRAME_CHECK_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic        clock_clk = 1'b0;
   logic        reset_n;
   logic [11:0] data_in;
   logic        sop_in, eop_in, valid_in;
   logic        ready_out;
   logic [23:0] data_out;
   logic        sop_out, eop_out, valid_out;
   logic        ready_in;
   logic [15:0] frame_count;
   logic        frame_err;

   int n_vec  = 0;
   int n_fail = 0;

   edge_scale_input #(.FRAME_W(FW), .FRAME_H(FH), .CNT_W(20)) dut (
      .clock_clk   (clock_clk),
      .reset_n     (reset_n),
      .data_in     (data_in),
      .sop_in      (sop_in),
      .eop_in      (eop_in),
      .valid_in    (valid_in),
      .ready_out   (ready_out),
      .data_out    (data_out),
      .sop_out     (sop_out),
      .eop_out     (eop_out),
      .valid_out   (valid_out),
      .ready_in    (ready_in),
      .frame_count (frame_count),
      .frame_err   (frame_err)
   );

   always #5 clock_clk = ~clock_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock_clk);
      #1;
   endtask

   task automatic beat(input logic [11:0] d, input logic s, input logic e);
      data_in  = d;
      sop_in   = s;
      eop_in   = e;
      valid_in = 1'b1;
   endtask

   task automatic idle();
      valid_in = 1'b0;
      sop_in   = 1'b0;
      eop_in   = 1'b0;
   endtask

   task automatic apply_reset();
      idle();
      ready_in = 1'b1;
      reset_n  = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n  = 1'b0;
      data_in  = 12'h000;
      ready_in = 1'b1;
      idle();
      #1;
      check("rst_valid", 32'(valid_out), 32'd0);
      check("rst_data", 32'(data_out), 32'd0);
      check("rst_sop_eop", 32'({sop_out, eop_out}), 32'd0);
      check("rst_ready", 32'(ready_out), 32'd1);
      check("rst_fcount", 32'(frame_count), 32'd0);
      check("rst_ferr", 32'(frame_err), 32'd0);
      tick();
      tick();
      reset_n = 1'b1;

      // 1: basic 4-beat packet, one-cycle latency
      beat(12'hF00, 1'b1, 1'b0); tick();
      check("t1_d0", 32'(data_out), 32'hFF0000);
      check("t1_sop", 32'({valid_out, sop_out, eop_out}), 32'b110);
      beat(12'h0F0, 1'b0, 1'b0); tick();
      check("t1_d1", 32'(data_out), 32'h00FF00);
      beat(12'h00F, 1'b0, 1'b0); tick();
      check("t1_d2", 32'(data_out), 32'h0000FF);
      beat(12'h888, 1'b0, 1'b1); tick();
      check("t1_d3", 32'(data_out), 32'h888888);
      check("t1_eop", 32'({valid_out, sop_out, eop_out}), 32'b101);
      check("t1_fcount", 32'(frame_count), 32'd1);
      idle(); tick();
      check("t1_drain", 32'(valid_out), 32'd0);
      check("t1_ferr", 32'(frame_err), 32'(ERR_EN));

      // 2: beats outside a packet are consumed and dropped
      apply_reset();
      beat(12'h123, 1'b0, 1'b0);
      check("t2_rdy0", 32'(ready_out), 32'd1);
      tick();
      check("t2_drop0", 32'(valid_out), 32'd0);
      beat(12'h456, 1'b0, 1'b1);
      check("t2_rdy1", 32'(ready_out), 32'd1);
      tick();
      check("t2_drop1", 32'(valid_out), 32'd0);
      check("t2_fcount", 32'(frame_count), 32'd0);
      idle();

      // 3: three-cycle downstream stall
      apply_reset();
      beat(12'h1A2, 1'b1, 1'b0); tick();
      check("t3_e1_data", 32'(data_out), 32'h11AA22);
      check("t3_e1_rdy", 32'(ready_out), 32'd1);
      ready_in = 1'b0;
      beat(12'h3B4, 1'b0, 1'b0); tick();
      check("t3_e2_rdy", 32'(ready_out), 32'd0);
      check("t3_e2_data", 32'(data_out), 32'h11AA22);
      beat(12'h5C6, 1'b0, 1'b0); tick();
      check("t3_e3_data", 32'(data_out), 32'h11AA22);
      check("t3_e3_rdy", 32'(ready_out), 32'd0);
      tick();
      check("t3_e4_data", 32'(data_out), 32'h11AA22);
      check("t3_e4_valid", 32'(valid_out), 32'd1);
      ready_in = 1'b1;
      tick();
      check("t3_e5_data", 32'(data_out), 32'h33BB44);
      check("t3_e5_rdy", 32'(ready_out), 32'd1);
      tick();
      check("t3_e6_data", 32'(data_out), 32'h55CC66);
      beat(12'h7D8, 1'b0, 1'b1); tick();
      check("t3_e7_data", 32'(data_out), 32'h77DD88);
      check("t3_e7_eop", 32'(eop_out), 32'd1);
      idle(); tick();
      check("t3_e8_valid", 32'(valid_out), 32'd0);
      check("t3_fcount", 32'(frame_count), 32'd1);

      // 4: short packet, then correct-length packet, then correct length after reset
      apply_reset();
      for (int i = 0; i < 7; i++) begin
         beat(12'(i * 12'h111), i == 0, i == 6); tick();
      end
      check("t4_short_data", 32'(data_out), 32'h666666);
      check("t4_short_ferr", 32'(frame_err), 32'(ERR_EN));
      check("t4_short_fcount", 32'(frame_count), 32'd1);
      idle();
      repeat (3) tick();
      check("t4_ferr_hold", 32'(frame_err), 32'(ERR_EN));
      for (int i = 0; i < 8; i++) begin
         beat(12'(i * 12'h111), i == 0, i == 7); tick();
      end
      check("t4_full_data", 32'(data_out), 32'h777777);
      check("t4_full_ferr", 32'(frame_err), 32'(ERR_EN));
      check("t4_full_fcount", 32'(frame_count), 32'd2);
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         beat(12'(i * 12'h111), i == 0, i == 7); tick();
      end
      check("t4_exact_ferr", 32'(frame_err), 32'd0);
      check("t4_exact_fcount", 32'(frame_count), 32'd1);
      idle();

      // 5: one-pixel packet, then reset with the skid register full
      apply_reset();
      beat(12'hFFF, 1'b1, 1'b1); tick();
      check("t5_px1_data", 32'(data_out), 32'hFFFFFF);
      check("t5_px1_flags", 32'({valid_out, sop_out, eop_out}), 32'b111);
      check("t5_px1_fcount", 32'(frame_count), 32'd1);
      check("t5_px1_ferr", 32'(frame_err), 32'(ERR_EN));
      idle(); tick();
      beat(12'hABC, 1'b1, 1'b0); tick();
      ready_in = 1'b0;
      beat(12'hDEF, 1'b0, 1'b0); tick();
      check("t5_skid_full", 32'(ready_out), 32'd0);
      reset_n = 1'b0;
      #1;
      check("t5_rst_valid", 32'(valid_out), 32'd0);
      check("t5_rst_data", 32'(data_out), 32'd0);
      check("t5_rst_flags", 32'({sop_out, eop_out}), 32'd0);
      check("t5_rst_ready", 32'(ready_out), 32'd1);
      check("t5_rst_fcount", 32'(frame_count), 32'd0);
      check("t5_rst_ferr", 32'(frame_err), 32'd0);
      tick();
      reset_n  = 1'b1;
      ready_in = 1'b1;
      beat(12'h111, 1'b0, 1'b0); tick();
      check("t5_drop0", 32'(valid_out), 32'd0);
      beat(12'h222, 1'b0, 1'b1); tick();
      check("t5_drop1", 32'(valid_out), 32'd0);
      check("t5_drop_fcount", 32'(frame_count), 32'd0);
      beat(12'h9AB, 1'b1, 1'b0); tick();
      check("t5_resume_valid", 32'(valid_out), 32'd1);
      check("t5_resume_data", 32'(data_out), 32'h99AABB);
      idle();

      // 6: sop while a packet is active restarts it
      apply_reset();
      beat(12'h100, 1'b1, 1'b0); tick();
      beat(12'h200, 1'b0, 1'b0); tick();
      check("t6_pre_ferr", 32'(frame_err), 32'd0);
      for (int i = 0; i < 8; i++) begin
         beat(12'h3C0 + 12'(i), i == 0, i == 7); tick();
         if (i == 0) begin
            check("t6_restart_data", 32'(data_out), 32'h33CC00);
            check("t6_restart_sop", 32'(sop_out), 32'd1);
         end
      end
      check("t6_last_data", 32'(data_out), 32'h33CC77);
      check("t6_last_eop", 32'(eop_out), 32'd1);
      check("t6_fcount", 32'(frame_count), 32'd1);
      check("t6_ferr", 32'(frame_err), 32'(ERR_EN));
      idle(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
